// File: rtl/xadac_pkg.sv
// xadac_pkg: shared widths and payload types for the xadac core/unit port
package xadac_pkg;
  localparam int VecDataWidth = 128;
  localparam int IdWidth = 4;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0] instr;
  } dec_req_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic accept;
    logic rd_write;
    logic vd_write;
  } dec_rsp_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [31:0] instr;
    logic [1:0][31:0] rs_data;
    logic [2:0][VecDataWidth-1:0] vs_data;
  } exe_req_t;
  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic rd_write;
    logic [31:0] rd_data;
    logic vd_write;
    logic [4:0] vd_addr;
    logic [VecDataWidth-1:0] vd_data;
  } exe_rsp_t;
endpackage

// File: rtl/xadac_if.sv
// xadac_if: decode and execute channels between a requester (mst) and a responder (slv)
interface xadac_if;
  import xadac_pkg::*;
  logic dec_req_valid;
  logic dec_req_ready;
  dec_req_t dec_req;
  logic dec_rsp_valid;
  dec_rsp_t dec_rsp;
  logic exe_req_valid;
  logic exe_req_ready;
  exe_req_t exe_req;
  logic exe_rsp_valid;
  logic exe_rsp_ready;
  exe_rsp_t exe_rsp;
  modport slv (
    input dec_req_valid, dec_req, exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );
  modport mst (
    output dec_req_valid, dec_req, exe_req_valid, exe_req, exe_rsp_ready,
    input dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
  );
endinterface

// File: rtl/xadac_vrf.sv
// xadac_vrf: vector register file and operand sequencer between core and vector unit
// clk/rstn: clock, synchronous active-low reset
// slv: core-facing xadac port; mst: execution-unit-facing xadac port
// ld_valid/ld_ready/ld_addr/ld_data: vector load write port into the register file
module xadac_vrf
  import xadac_pkg::*;
#(
  parameter int NrVregs = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  xadac_if.slv                    slv,
  xadac_if.mst                    mst,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4:0]              ld_addr,
  input  logic [VecDataWidth-1:0] ld_data
);
  typedef enum logic [1:0] {IDLE, READ, ISSUE, WB} state_e;
  state_e state_q, state_d;
  exe_req_t req_q, req_d;
  exe_rsp_t rsp_q, rsp_d, rsp_o;
  logic req_done_q, req_done_d;
  logic [VecDataWidth-1:0] vrf_q [NrVregs];
  logic [VecDataWidth-1:0] vrf_d [NrVregs];
  logic wb_fire;
  assign mst.dec_req_valid = slv.dec_req_valid;
  assign mst.dec_req = slv.dec_req;
  assign slv.dec_req_ready = mst.dec_req_ready;
  assign slv.dec_rsp_valid = mst.dec_rsp_valid;
  assign slv.dec_rsp = mst.dec_rsp;
  assign slv.exe_req_ready = state_q == IDLE;
  assign mst.exe_req_valid = state_q == ISSUE && !req_done_q;
  assign mst.exe_req = mst.exe_req_valid ? req_q : '0;
  assign mst.exe_rsp_ready = state_q == ISSUE;
  assign slv.exe_rsp_valid = state_q == WB;
  assign slv.exe_rsp = state_q == WB ? rsp_o : '0;
  assign wb_fire = state_q == WB && slv.exe_rsp_ready;
  // the write-back port is shared with loads, so the WB write wins its cycle
  assign ld_ready = !(wb_fire && rsp_q.vd_write);
  always_comb begin
    rsp_o = rsp_q;
    rsp_o.vd_write = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    rsp_d = rsp_q;
    req_done_d = req_done_q;
    vrf_d = vrf_q;
    unique case (state_q)
      IDLE: begin
        if (slv.exe_req_valid) begin
          req_d = slv.exe_req;
          state_d = READ;
        end
      end
      READ: begin
        req_d.vs_data[0] = vrf_q[req_q.instr[19:15]];
        req_d.vs_data[1] = vrf_q[req_q.instr[24:20]];
        req_d.vs_data[2] = vrf_q[req_q.instr[11:7]];
        state_d = ISSUE;
      end
      ISSUE: begin
        if (mst.exe_req_valid && mst.exe_req_ready) req_done_d = 1'b1;
        // a response only counts once its request has been (or is being) accepted
        if (mst.exe_rsp_valid && (req_done_q || mst.exe_req_ready)) begin
          rsp_d = mst.exe_rsp;
          req_done_d = 1'b0;
          state_d = WB;
        end
      end
      WB: begin
        if (slv.exe_rsp_ready) begin
          if (rsp_q.vd_write) vrf_d[rsp_q.vd_addr] = rsp_q.vd_data;
          state_d = IDLE;
        end
      end
    endcase
    if (ld_valid && ld_ready) vrf_d[ld_addr] = ld_data;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_q <= '0;
      rsp_q <= '0;
      req_done_q <= 1'b0;
      vrf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      rsp_q <= rsp_d;
      req_done_q <= req_done_d;
      vrf_q <= vrf_d;
    end
  end
endmodule

// File: tb/tb_xadac_vrf.sv
// tb_xadac_vrf: scoreboard bench for xadac_vrf with a behavioural vmacc unit on the mst side
module tb_xadac_vrf;
  import xadac_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ld_valid, ld_ready;
  logic [4:0] ld_addr;
  logic [VecDataWidth-1:0] ld_data;
  always #5 clk = ~clk;
  xadac_if core_if();
  xadac_if unit_if();
  xadac_vrf #(.NrVregs(32)) dut (
    .clk(clk), .rstn(rstn), .slv(core_if), .mst(unit_if),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  int tests = 0;
  int fails = 0;
  logic [VecDataWidth-1:0] ref_vrf [32];
  exe_req_t op_q [$];
  exe_rsp_t exp_q [$];
  bit unit_hold = 1'b0;
  bit zero_lat = 1'b0;
  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [VecDataWidth-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [31:0] mk(input logic [6:0] op, input int vd, input int vs1, input int vs2, input int len);
    logic [31:0] i = '0;
    i[6:0] = op;
    i[11:7] = 5'(vd);
    i[19:15] = 5'(vs1);
    i[24:20] = 5'(vs2);
    i[27:25] = 3'(len);
    return i;
  endfunction
  // vmacc: each of the first len 32-bit lanes accumulates the dot product of its four byte pairs
  function automatic exe_rsp_t vmacc(input exe_req_t r);
    exe_rsp_t s = '0;
    s.id = r.id;
    s.vd_addr = r.instr[11:7];
    if (r.instr[6:0] == 7'h57) begin
      s.vd_write = 1'b1;
      for (int l = 0; l < 4; l++) begin
        logic [31:0] acc = r.vs_data[2][32*l +: 32];
        if (l < int'(r.instr[27:25]))
          for (int b = 0; b < 4; b++)
            acc += 32'(r.vs_data[0][32*l+8*b +: 8]) * 32'(r.vs_data[1][32*l+8*b +: 8]);
        s.vd_data[32*l +: 32] = acc;
      end
    end else begin
      s.rd_write = 1'b1;
      s.rd_data = r.vs_data[0][31:0] ^ r.vs_data[1][31:0] ^ r.rs_data[0];
    end
    return s;
  endfunction
  task automatic predict(input exe_req_t r, output exe_rsp_t core_exp);
    exe_req_t q = r;
    exe_rsp_t s;
    q.vs_data[0] = ref_vrf[r.instr[19:15]];
    q.vs_data[1] = ref_vrf[r.instr[24:20]];
    q.vs_data[2] = ref_vrf[r.instr[11:7]];
    s = vmacc(q);
    op_q.push_back(q);
    if (s.vd_write) ref_vrf[s.vd_addr] = s.vd_data;
    s.vd_write = 1'b0;
    exp_q.push_back(s);
    core_exp = s;
  endtask
  task automatic issue(input exe_req_t r, output int lat, output exe_rsp_t e);
    int n = 0;
    core_if.exe_req = r;
    core_if.exe_req_valid = 1'b1;
    while (!core_if.exe_req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_accept", 512'(core_if.exe_req_ready), 512'(1'b1));
    predict(r, e);
    @(posedge clk); #1;
    core_if.exe_req_valid = 1'b0;
    core_if.exe_req = '0;
    lat = 1;
    while (!core_if.exe_rsp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("rsp_arrive", 512'(core_if.exe_rsp_valid), 512'(1'b1));
  endtask
  task automatic drain(input bit rand_bp);
    int n = 0;
    while (core_if.exe_rsp_valid && n < 60) begin
      core_if.exe_rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_drain", 512'(core_if.exe_rsp_valid), 512'(1'b0));
    core_if.exe_rsp_ready = 1'b1;
  endtask
  task automatic load(input int a, input logic [VecDataWidth-1:0] d);
    int n = 0;
    ld_valid = 1'b1;
    ld_addr = 5'(a);
    ld_data = d;
    while (!ld_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ref_vrf[a] = d;
  endtask
  initial begin
    exe_req_t r;
    exe_rsp_t s;
    int lat;
    unit_if.exe_req_ready = 1'b0;
    unit_if.exe_rsp_valid = 1'b0;
    unit_if.exe_rsp = '0;
    forever begin
      @(posedge clk); #1;
      if (unit_if.exe_req_valid && !unit_hold) begin
        repeat (zero_lat ? 0 : $urandom_range(0, 2)) begin @(posedge clk); #1; end
        r = unit_if.exe_req;
        s = vmacc(r);
        lat = zero_lat ? 0 : int'($urandom_range(0, 2));
        unit_if.exe_req_ready = 1'b1;
        if (lat == 0) begin
          unit_if.exe_rsp = s;
          unit_if.exe_rsp_valid = 1'b1;
        end
        @(posedge clk); #1;
        unit_if.exe_req_ready = 1'b0;
        if (lat != 0) begin
          repeat (lat - 1) begin @(posedge clk); #1; end
          unit_if.exe_rsp = s;
          unit_if.exe_rsp_valid = 1'b1;
          @(posedge clk); #1;
        end
        unit_if.exe_rsp_valid = 1'b0;
        unit_if.exe_rsp = '0;
      end
    end
  end
  always @(negedge clk) begin
    if (rstn && unit_if.exe_req_valid && unit_if.exe_req_ready) begin
      if (op_q.size() == 0) chk("unexpected_issue", 512'(unit_if.exe_req), 512'(0));
      else chk("issue_operands", 512'(unit_if.exe_req), 512'(op_q.pop_front()));
    end
    if (rstn && core_if.exe_rsp_valid && core_if.exe_rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 512'(core_if.exe_rsp), 512'(0));
      else chk("core_rsp", 512'(core_if.exe_rsp), 512'(exp_q.pop_front()));
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    exe_req_t r;
    exe_rsp_t e;
    int lat, n;
    logic [VecDataWidth-1:0] d;
    dec_req_t dreq;
    dec_rsp_t drsp;
    core_if.dec_req_valid = 1'b0;
    core_if.dec_req = '0;
    core_if.exe_req_valid = 1'b0;
    core_if.exe_req = '0;
    core_if.exe_rsp_ready = 1'b1;
    unit_if.dec_req_ready = 1'b0;
    unit_if.dec_rsp_valid = 1'b0;
    unit_if.dec_rsp = '0;
    ld_valid = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    foreach (ref_vrf[i]) ref_vrf[i] = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 512'({core_if.exe_req_ready, core_if.exe_rsp_valid, unit_if.exe_req_valid,
        unit_if.exe_rsp_ready, ld_ready}), 512'(5'b10001));
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_outputs", 512'({core_if.exe_req_ready, core_if.exe_rsp_valid, unit_if.exe_req_valid,
        unit_if.exe_rsp_ready, ld_ready}), 512'(5'b10001));
    r = '0;
    r.id = 4'd1;
    r.instr = mk(7'h57, 0, 0, 0, 4);
    issue(r, lat, e);
    chk("v0_mac_zero", 512'(core_if.exe_rsp.vd_data), 512'(0));
    drain(1'b0);
    load(1, {16{8'h02}});
    load(2, {16{8'h03}});
    load(3, {4{32'd10}});
    zero_lat = 1'b1;
    r.id = 4'd2;
    r.instr = mk(7'h57, 3, 1, 2, 4);
    issue(r, lat, e);
    chk("mac_latency", 512'(lat), 512'(3));
    chk("mac_vd_write_cleared", 512'(core_if.exe_rsp.vd_write), 512'(1'b0));
    chk("mac_lanes_34", 512'(core_if.exe_rsp.vd_data), 512'({4{32'd34}}));
    drain(1'b0);
    zero_lat = 1'b0;
    core_if.exe_rsp_ready = 1'b0;
    r.id = 4'd3;
    r.instr = mk(7'h57, 4, 1, 3, 4);
    issue(r, lat, e);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 512'(core_if.exe_rsp_valid), 512'(1'b1));
      chk("bp_payload", 512'(core_if.exe_rsp), 512'(e));
      chk("bp_req_ready", 512'(core_if.exe_req_ready), 512'(1'b0));
      chk("bp_ld_ready", 512'(ld_ready), 512'(1'b1));
      @(posedge clk); #1;
    end
    drain(1'b0);
    core_if.exe_rsp_ready = 1'b0;
    r.id = 4'd4;
    r.instr = mk(7'h57, 3, 1, 2, 4);
    issue(r, lat, e);
    d = rnd_vec();
    ld_valid = 1'b1;
    ld_addr = 5'd5;
    ld_data = d;
    core_if.exe_rsp_ready = 1'b1;
    #1;
    chk("collide_ld_ready", 512'(ld_ready), 512'(1'b0));
    @(posedge clk); #1;
    chk("collide_ld_next", 512'(ld_ready), 512'(1'b1));
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ref_vrf[5] = d;
    r.id = 4'd5;
    r.instr = mk(7'h0b, 0, 3, 5, 0);
    issue(r, lat, e);
    drain(1'b0);
    load(1, rnd_vec() | 128'd1);
    unit_hold = 1'b1;
    r.id = 4'd6;
    r.instr = mk(7'h57, 6, 1, 1, 4);
    core_if.exe_req = r;
    core_if.exe_req_valid = 1'b1;
    n = 0;
    while (!core_if.exe_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    core_if.exe_req_valid = 1'b0;
    n = 0;
    while (!unit_if.exe_req_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("midflight_reach_issue", 512'(unit_if.exe_req_valid), 512'(1'b1));
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    foreach (ref_vrf[i]) ref_vrf[i] = '0;
    chk("midflight_idle", 512'(core_if.exe_req_ready), 512'(1'b1));
    for (int i = 0; i < 8; i++) begin
      chk("midflight_no_rsp", 512'({core_if.exe_rsp_valid, unit_if.exe_req_valid}), 512'(0));
      @(posedge clk); #1;
    end
    unit_hold = 1'b0;
    r.id = 4'd7;
    r.instr = mk(7'h0b, 0, 1, 1, 0);
    r.rs_data[0] = $urandom;
    issue(r, lat, e);
    chk("v1_after_reset", 512'(core_if.exe_rsp.rd_data), 512'(r.rs_data[0]));
    drain(1'b0);
    dreq.id = 4'd7;
    dreq.instr = $urandom;
    drsp.id = 4'd7;
    drsp.accept = 1'b1;
    drsp.rd_write = 1'b0;
    drsp.vd_write = 1'b1;
    core_if.dec_req_valid = 1'b1;
    core_if.dec_req = dreq;
    unit_if.dec_req_ready = 1'b1;
    unit_if.dec_rsp_valid = 1'b1;
    unit_if.dec_rsp = drsp;
    #1;
    chk("dec_req_fwd", 512'({unit_if.dec_req_valid, unit_if.dec_req}), 512'({1'b1, dreq}));
    chk("dec_ready_back", 512'(core_if.dec_req_ready), 512'(1'b1));
    chk("dec_rsp_back", 512'({core_if.dec_rsp_valid, core_if.dec_rsp}), 512'({1'b1, drsp}));
    core_if.dec_req_valid = 1'b0;
    unit_if.dec_req_ready = 1'b0;
    unit_if.dec_rsp_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, 7)), rnd_vec());
      r.id = 4'($urandom);
      r.rs_data = {$urandom, $urandom};
      r.vs_data = {rnd_vec(), rnd_vec(), rnd_vec()};
      r.instr = mk($urandom_range(0, 1) ? 7'h57 : 7'h0b, int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      core_if.exe_rsp_ready = 1'($urandom_range(0, 1));
      issue(r, lat, e);
      drain(1'b1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 512'({op_q.size(), exp_q.size()}), 512'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
